// File: rtl/sii_l2t_req_sched.sv
// Schedules ordered/bypass requesters onto eight per-bank 32-bit L2T request buses under per-bank input-queue credits.
// Build option: SII_L2T_SCHED_WIB_CREDIT_EN adds per-bank write-buffer credits that gate payload-carrying packets.
module sii_l2t_req_sched #(
    parameter int CREDITS     = 4,
    parameter int WIB_CREDITS = 1
) (
    input  logic         iol2clk,
    input  logic         rst,
    input  logic         r0_vld,
    input  logic [63:0]  r0_hdr,
    input  logic [2:0]   r0_bank,
    input  logic         r0_has_data,
    input  logic         r1_vld,
    input  logic [63:0]  r1_hdr,
    input  logic [2:0]   r1_bank,
    input  logic         r1_has_data,
    output logic         r0_ack,
    output logic         r1_ack,
    output logic         pld_rd,
    output logic         pld_src,
    output logic [3:0]   pld_idx,
    input  logic [31:0]  pld_data,
    output logic [255:0] sii_l2t_req,
    output logic [7:0]   sii_l2t_req_vld,
    input  logic [7:0]   l2t_sii_iq_dequeue,
    input  logic [7:0]   l2t_sii_wib_dequeue,
    output logic         credit_err
);
    localparam logic [2:0] IQ_MAX = 3'(CREDITS);

    typedef enum logic [2:0] {IDLE, VLD, HDR0, HDR1, DUMMY0, DUMMY1, PLD} state_t;

    state_t      state_reg;
    logic [63:0] hdr_reg;
    logic [2:0]  bank_reg;
    logic        has_data_reg;
    logic        src_reg;
    logic [3:0]  beat_reg;
    logic [31:0] word_reg;
    logic        ptr_reg;
    logic [1:0]  ack_reg;
    logic [7:0]  req_vld_reg;
    logic        pld_rd_reg;
    logic        pld_src_reg;
    logic [3:0]  pld_idx_reg;
    logic        credit_err_reg;
    logic [2:0]  iq_cnt_reg [8];

    logic        elig0;
    logic        elig1;
    logic        gnt_any;
    logic        gnt_src;
    logic [2:0]  gnt_bank;
    logic [63:0] gnt_hdr;
    logic        gnt_has_data;
    logic [7:0]  iq_dec;
    logic [7:0]  iq_ovf;
    logic [7:0]  cred_ovf;
    logic        busy;
    logic [31:0] bus_word;

`ifdef SII_L2T_SCHED_WIB_CREDIT_EN
    localparam logic [2:0] WIB_MAX = 3'(WIB_CREDITS);
    logic [2:0] wib_cnt_reg [8];
    logic [7:0] wib_dec;
    logic [7:0] wib_ovf;

    assign elig0 = r0_vld && (iq_cnt_reg[r0_bank] != 3'd0) &&
                   (!r0_has_data || (wib_cnt_reg[r0_bank] != 3'd0));
    assign elig1 = r1_vld && (iq_cnt_reg[r1_bank] != 3'd0) &&
                   (!r1_has_data || (wib_cnt_reg[r1_bank] != 3'd0));
    assign cred_ovf = iq_ovf | wib_ovf;

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 8; b++) wib_cnt_reg[b] <= WIB_MAX;
        end else begin
            for (int b = 0; b < 8; b++) begin
                if (wib_dec[b] && !l2t_sii_wib_dequeue[b])
                    wib_cnt_reg[b] <= wib_cnt_reg[b] - 3'd1;
                else if (!wib_dec[b] && l2t_sii_wib_dequeue[b] && !wib_ovf[b])
                    wib_cnt_reg[b] <= wib_cnt_reg[b] + 3'd1;
            end
        end
    end
`else
    logic unused_wib;

    assign elig0 = r0_vld && (iq_cnt_reg[r0_bank] != 3'd0);
    assign elig1 = r1_vld && (iq_cnt_reg[r1_bank] != 3'd0);
    assign cred_ovf = iq_ovf;
    assign unused_wib = ^{l2t_sii_wib_dequeue, 3'(WIB_CREDITS)};
`endif

    // ptr_reg=1 gives r1 priority; an ineligible favoured requester never blocks the other one.
    assign gnt_any      = (state_reg == IDLE) && (elig0 || elig1);
    assign gnt_src      = elig1 && (ptr_reg || !elig0);
    assign gnt_bank     = gnt_src ? r1_bank : r0_bank;
    assign gnt_hdr      = gnt_src ? r1_hdr : r0_hdr;
    assign gnt_has_data = gnt_src ? r1_has_data : r0_has_data;

    assign busy     = (state_reg != IDLE);
    assign bus_word = (state_reg == PLD) ? pld_data : word_reg;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_bank
            assign iq_dec[gi] = gnt_any && (gnt_bank == 3'(gi));
            assign iq_ovf[gi] = l2t_sii_iq_dequeue[gi] && !iq_dec[gi] && (iq_cnt_reg[gi] == IQ_MAX);
`ifdef SII_L2T_SCHED_WIB_CREDIT_EN
            assign wib_dec[gi] = iq_dec[gi] && gnt_has_data;
            assign wib_ovf[gi] = l2t_sii_wib_dequeue[gi] && !wib_dec[gi] && (wib_cnt_reg[gi] == WIB_MAX);
`endif
            assign sii_l2t_req[32*gi +: 32] = (busy && (bank_reg == 3'(gi))) ? bus_word : 32'h0;
        end
    endgenerate

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            for (int b = 0; b < 8; b++) iq_cnt_reg[b] <= IQ_MAX;
            credit_err_reg <= 1'b0;
        end else begin
            // A grant and a dequeue on the same bank cancel out.
            for (int b = 0; b < 8; b++) begin
                if (iq_dec[b] && !l2t_sii_iq_dequeue[b])
                    iq_cnt_reg[b] <= iq_cnt_reg[b] - 3'd1;
                else if (!iq_dec[b] && l2t_sii_iq_dequeue[b] && !iq_ovf[b])
                    iq_cnt_reg[b] <= iq_cnt_reg[b] + 3'd1;
            end
            if (|cred_ovf) credit_err_reg <= 1'b1;
        end
    end

    always_ff @(posedge iol2clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            hdr_reg      <= 64'h0;
            bank_reg     <= 3'd0;
            has_data_reg <= 1'b0;
            src_reg      <= 1'b0;
            beat_reg     <= 4'd0;
            word_reg     <= 32'h0;
            ptr_reg      <= 1'b0;
            ack_reg      <= 2'b00;
            req_vld_reg  <= 8'h0;
            pld_rd_reg   <= 1'b0;
            pld_src_reg  <= 1'b0;
            pld_idx_reg  <= 4'd0;
        end else begin
            case (state_reg)
                IDLE: begin
                    word_reg <= 32'h0;
                    if (gnt_any) begin
                        state_reg    <= VLD;
                        hdr_reg      <= gnt_hdr;
                        bank_reg     <= gnt_bank;
                        has_data_reg <= gnt_has_data;
                        src_reg      <= gnt_src;
                        ptr_reg      <= ~gnt_src;
                        ack_reg      <= gnt_src ? 2'b10 : 2'b01;
                        req_vld_reg  <= 8'h01 << gnt_bank;
                    end
                end
                VLD: begin
                    state_reg   <= HDR0;
                    ack_reg     <= 2'b00;
                    req_vld_reg <= 8'h0;
                    word_reg    <= hdr_reg[63:32];
                end
                HDR0: begin
                    state_reg <= HDR1;
                    word_reg  <= hdr_reg[31:0];
                    // Payload fetch runs one cycle ahead of the bus since pld_data lags pld_rd.
                    if (has_data_reg) begin
                        pld_rd_reg  <= 1'b1;
                        pld_idx_reg <= 4'd0;
                        pld_src_reg <= src_reg;
                    end
                end
                HDR1: begin
                    word_reg <= 32'h0;
                    if (has_data_reg) begin
                        state_reg   <= PLD;
                        beat_reg    <= 4'd0;
                        pld_idx_reg <= 4'd1;
                    end else begin
                        state_reg <= DUMMY0;
                    end
                end
                DUMMY0: state_reg <= DUMMY1;
                DUMMY1: state_reg <= IDLE;
                PLD: begin
                    beat_reg <= beat_reg + 4'd1;
                    if (beat_reg == 4'd15) state_reg <= IDLE;
                    if (beat_reg <= 4'd13) begin
                        pld_idx_reg <= beat_reg + 4'd2;
                    end else begin
                        pld_rd_reg  <= 1'b0;
                        pld_idx_reg <= 4'd0;
                        pld_src_reg <= 1'b0;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign r0_ack          = ack_reg[0];
    assign r1_ack          = ack_reg[1];
    assign sii_l2t_req_vld = req_vld_reg;
    assign pld_rd          = pld_rd_reg;
    assign pld_src         = pld_src_reg;
    assign pld_idx         = pld_idx_reg;
    assign credit_err      = credit_err_reg;

endmodule

// File: doc/sii_l2t_req_sched.md
SII_L2T_REQ_SCHED -- requirements
Module: sii_l2t_req_sched

Interface
REQ-001 SHALL have parameter: CREDITS, 4, per-bank L2T input-queue entries (legal 1..7).
REQ-002 SHALL have parameter: WIB_CREDITS, 1, per-bank write-buffer entries (legal 1..7).
REQ-003 SHALL have ports:
- iol2clk  in  1  clock.
- rst  in  1  reset; one clock; asynchronous, active-high.
- r0_vld / r1_vld  in  1  requester 0 (ordered) / requester 1 (bypass) packet pending.
- r0_hdr / r1_hdr  in  64  packet header.
- r0_bank / r1_bank  in  3  target L2T bank.
- r0_has_data / r1_has_data  in  1  packet carries 64B payload (WRI).
- r0_ack / r1_ack  out  1  grant pulse.
- pld_rd  out  1  payload read strobe.
- pld_src  out  1  payload source requester.
- pld_idx  out  4  payload word index.
- pld_data  in  32  payload word; valid the cycle after pld_rd.
- sii_l2t_req  out  256  bank n request bus at [32n+31:32n].
- sii_l2t_req_vld  out  8  per-bank packet start.
- l2t_sii_iq_dequeue  in  8  per-bank IQ credit return.
- l2t_sii_wib_dequeue  in  8  per-bank WIB credit return.
- credit_err  out  1  sticky credit overflow.

Function
REQ-004 SHALL keep per-bank iq_cnt, range 0..CREDITS; a requester is eligible when vld=1 and iq_cnt[bank]>0.
REQ-005 SHALL use FSM IDLE -> VLD -> HDR0 -> HDR1 -> then DUMMY0 -> DUMMY1 -> IDLE if has_data=0, or PLD(16 cycles) -> IDLE if has_data=1.
REQ-006 SHALL arbitrate only in IDLE: round-robin between eligible requesters; pointer starts at r0 and, after each grant, points to the non-granted requester.
REQ-007 SHALL not let an ineligible requester block an eligible one.
REQ-008 SHALL, on a grant in IDLE at cycle T, capture hdr/bank/has_data/source and enter VLD at T+1.
REQ-009 SHALL assert rN_ack for exactly the VLD cycle. The requester holds its inputs stable until ack and may change them the cycle after ack.
REQ-010 SHALL, in VLD, drive sii_l2t_req_vld[bank]=1 and its bus to 0.
REQ-011 SHALL drive the bus with hdr[63:32] in HDR0 and hdr[31:0] in HDR1.
REQ-012 SHALL drive the bus to 0 in DUMMY0 and DUMMY1.
REQ-013 SHALL, in PLD cycle k (k=0..15), drive the bus with pld_data returned for index k.
REQ-014 SHALL assert pld_rd with pld_idx=k and pld_src=captured source in the cycle before PLD cycle k, i.e. from HDR1 through PLD cycle 14.
REQ-015 SHALL drive every bus and vld bit not belonging to the active bank/state to 0; at most one vld bit is 1 per cycle.
REQ-016 SHALL give a minimum IDLE of 1 cycle between packets, so back-to-back packet spacing is 6 cycles (no data) or 20 cycles (data).
REQ-017 SHALL decrement iq_cnt[bank] at grant.
REQ-018 SHALL increment iq_cnt[n] on each cycle l2t_sii_iq_dequeue[n]=1.
REQ-019 SHALL leave iq_cnt unchanged when grant and dequeue hit the same bank in the same cycle.
REQ-020 SHALL, on a dequeue with iq_cnt[n]=CREDITS, hold the count at CREDITS and set credit_err, which stays set until reset.
REQ-021 SHALL act on dequeue inputs in every state, including mid-packet.

Reset
REQ-022 SHALL, while rst=1, asynchronously force: state IDLE, all outputs 0 (sii_l2t_req, sii_l2t_req_vld, r*_ack, pld_rd, pld_idx, pld_src, credit_err), iq_cnt=CREDITS, wib_cnt=WIB_CREDITS, pointer=r0.
REQ-023 SHALL, on reset mid-packet, abort the packet with no further bus cycles and no credit restoration beyond the reset values.

Configuration
REQ-024 SHALL, with SII_L2T_SCHED_WIB_CREDIT_EN defined, keep per-bank wib_cnt with the same rules as iq_cnt (REQ-017..REQ-021) on l2t_sii_wib_dequeue.
REQ-025 SHALL, with SII_L2T_SCHED_WIB_CREDIT_EN defined, require wib_cnt[bank]>0 as an additional condition for has_data=1 eligibility; overflow also sets credit_err.
REQ-026 SHALL, with SII_L2T_SCHED_WIB_CREDIT_EN undefined, ignore l2t_sii_wib_dequeue, keep no wib_cnt, and gate eligibility on iq_cnt only.

Verification
REQ-027 SHALL cover: r0 only, bank 3, hdr=0x1234_5678_9ABC_DEF0, has_data=0 -> bus3 reads 0 (vld), 0x12345678, 0x9ABCDEF0, 0, 0; ack in the vld cycle; iq_cnt[3]=3.
REQ-028 SHALL cover: r0 and r1 both valid continuously to bank 0 with iq_dequeue[0] tied 1 -> grants alternate r0, r1, r0, ...; never two vld bits set.
REQ-029 SHALL cover: 5 packets to bank 5 with no dequeue (CREDITS=4) -> 4 packets issue and the 5th stalls; a single iq_dequeue[5] pulse -> the 5th issues.
REQ-030 SHALL cover: has_data=1 with pld_data=idx+0xA0 -> 16 PLD cycles carrying 0xA0..0xAF in order; pld_rd high for 16 consecutive cycles starting at HDR1.
REQ-031 SHALL cover: iq_dequeue[2] asserted at iq_cnt[2]=4 -> credit_err=1, cnt stays 4; grant plus dequeue on bank 2 in one cycle -> cnt unchanged.
REQ-032 SHALL cover: rst asserted during PLD cycle 7 -> all outputs 0 immediately; iq_cnt all =4 after release.
